// File: rtl/clkgen_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding, the minimum legal divide ratio and the default ratio width.
package clkgen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Ratios below this are clamped up when captured; also the reset ratio.
    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_DIV_W = 16;

endpackage

// File: rtl/clkgen_chan.sv
// One divider channel: shadow/active ratio, counter, IDLE/RUN state and
// registered clk_out/tick. Optional phase start offset when CLKGEN_PHASE_EN
// is defined.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int DIV_W   = DEFAULT_DIV_W
`ifdef CLKGEN_PHASE_EN
    ,
    parameter int PHASE_W = DIV_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DIV_W-1:0]   div,
    input  logic               load,
`ifdef CLKGEN_PHASE_EN
    input  logic [PHASE_W-1:0] phase,
`endif
    output logic               clk_out,
    output logic               tick
);

    chan_state_t      state_reg, state_next;
    logic [DIV_W-1:0] s_reg, s_next;
    logic [DIV_W-1:0] n_reg, n_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] start_val;

`ifdef CLKGEN_PHASE_EN
    localparam int CMP_W = (PHASE_W > DIV_W) ? PHASE_W : DIV_W;
    logic [CMP_W-1:0] phase_ext;
    logic [CMP_W-1:0] ratio_ext;

    // Start offset is honoured only if it lies inside the period about to begin.
    always_comb begin
        phase_ext = CMP_W'(phase);
        ratio_ext = CMP_W'(s_next);
        start_val = (phase_ext < ratio_ext) ? DIV_W'(phase) : '0;
    end
`else
    assign start_val = '0;
`endif

    // Clamp the incoming ratio and pick the shadow value for this edge; a load
    // coinciding with a wrap or with IDLE is taken straight into the active ratio.
    always_comb begin
        div_clamped = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
        s_next      = load ? div_clamped : s_reg;
    end

    // Next-state logic; outputs are judged against the ratio in force for cnt_next.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        n_next       = n_reg;
        clk_out_next = 1'b0;
        tick_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                n_next   = s_next;
                cnt_next = '0;
                if (en) begin
                    state_next   = RUN;
                    cnt_next     = start_val;
                    clk_out_next = (start_val < (s_next >> 1));
                    tick_next    = (start_val == '0);
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    n_next     = s_next;
                end else begin
                    if (cnt_reg == n_reg - DIV_W'(1)) begin
                        cnt_next = '0;
                        n_next   = s_next;
                    end else begin
                        cnt_next = cnt_reg + DIV_W'(1);
                    end
                    clk_out_next = (cnt_next < (n_next >> 1));
                    tick_next    = (cnt_next == '0);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any captured ratio.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            s_reg       <= DIV_W'(MIN_DIV);
            n_reg       <= DIV_W'(MIN_DIV);
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_reg       <= s_next;
            n_reg       <= n_next;
            cnt_reg     <= cnt_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider top. Slices the packed ratio
// (and, with CLKGEN_PHASE_EN defined, phase) buses into independent channels.
module clock_div_gen
    import clkgen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = DEFAULT_DIV_W
`ifdef CLKGEN_PHASE_EN
    ,
    parameter int PHASE_W  = DIV_W
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CHANNELS-1:0]         en,
    input  logic [CHANNELS*DIV_W-1:0]   div,
    input  logic [CHANNELS-1:0]         load,
`ifdef CLKGEN_PHASE_EN
    input  logic [CHANNELS*PHASE_W-1:0] phase,
`endif
    output logic [CHANNELS-1:0]         clk_out,
    output logic [CHANNELS-1:0]         tick
);

    // One fully independent divider per channel.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            clkgen_chan #(
                .DIV_W   (DIV_W)
`ifdef CLKGEN_PHASE_EN
                ,
                .PHASE_W (PHASE_W)
`endif
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en[gi]),
                .div     (div[gi*DIV_W +: DIV_W]),
                .load    (load[gi]),
`ifdef CLKGEN_PHASE_EN
                .phase   (phase[gi*PHASE_W +: PHASE_W]),
`endif
                .clk_out (clk_out[gi]),
                .tick    (tick[gi])
            );
        end
    endgenerate

endmodule

// File: doc/clock_div_gen.md
# clock_div_gen

Multi-channel programmable clock divider that derives CHANNELS divided clock signals and matching one-cycle tick strobes from the single system clock. It replaces the fixed, simulation-only clock source with synthesizable per-channel dividers. Each channel has its own enable and a divide ratio that can be reloaded at run time without glitches. Downstream blocks consume the tick strobes as clock enables; the divided clocks are for observation and export.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- DIV_W, 16, width of each divide ratio field
- PHASE_W, DIV_W, width of each phase offset field (only when CLKGEN_PHASE_EN is defined)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  CHANNELS  per-channel run enable
- div  in  CHANNELS*DIV_W  packed divide ratios, channel i at bits [i*DIV_W +: DIV_W]
- load  in  CHANNELS  per-channel pulse: capture div field into shadow register
- phase  in  CHANNELS*PHASE_W  packed start offsets (CLKGEN_PHASE_EN only)
- clk_out  out  CHANNELS  divided clocks, registered
- tick  out  CHANNELS  one-cycle strobe, high in the cycle where clk_out rises or restarts high

## Operation
- Per-channel registers: shadow ratio S, active ratio N, counter cnt (DIV_W bits), state in {IDLE, RUN}, clk_out, tick.
- Effective ratio: any div value below 2 is clamped to 2 at capture. half = N >> 1 (floor).
- load[i]=1 captures the clamped div field into S. The latest load wins. load while rst_n=0 is ignored.
- IDLE: cnt=0, clk_out=0, tick=0, N<=S every cycle. en=1 moves to RUN; on that edge cnt<=start, where start is 0, or the phase offset in phase mode.
- RUN, en=1: cnt<=(cnt==N-1)?0:cnt+1. On wrap (cnt==N-1), N<=S; the wrap compare uses the old N. clk_out and tick follow the output rule below.
- RUN, en=0: go to IDLE. clk_out and tick go to 0 on that same edge. Truncating a high phase is allowed.
- Output rule: on every edge where the channel is in RUN or entering RUN, clk_out<=(cnt_next<half) and tick<=(cnt_next==0), with both evaluated against the N in force for cnt_next.
- Simultaneous load and wrap: the wrap uses the old N, and the next period uses the newly captured value.
- Channels are fully independent. No cross-channel synchronisation.

## Timing
- Reset values: all clk_out=0, tick=0, cnt=0, state=IDLE, N=S=2.
- Reset mid-operation: all channels go to IDLE on the next edge. The prior S is discarded.
- Latency en rise to first clk_out/tick high: 1 clk edge.
- Period = N cycles. High time = floor(N/2) cycles. Low time = ceil(N/2) cycles.
- New ratio takes effect at the first wrap after load, or immediately if the channel is IDLE. No runt pulses.

## Configuration
- CLKGEN_PHASE_EN defined: the phase port exists. On IDLE->RUN, start = phase field if it is less than the current N, otherwise 0. Outputs follow the output rule, so tick fires only when cnt reaches 0.
- Not defined: the phase port is absent, and start = 0 for every channel.

## Structure
- Package clkgen_pkg holds the state enum (IDLE, RUN), MIN_DIV=2, and the default DIV_W.
- Sub-module clkgen_chan implements one channel: state, counter, shadow/active ratio, and output registers. The top module instantiates CHANNELS copies in a generate loop and slices the packed buses.

## Test plan
- Reset: hold rst_n=0 for 4 cycles with en=all 1 -> clk_out=0 and tick=0 throughout. On the first edge after release, every channel has clk_out=1 and tick=1.
- Ratios: ch0 div=4, ch1 div=5, ch2 div=0 -> ch0 pattern 1100, ch1 pattern 11000, ch2 pattern 10. Ticks at periods 4, 5 and 2.
- Glitch-free reload: ch0 running div=4, pulse load with div=8 at cnt=1 -> current 4-cycle period completes, then the 11110000 pattern. No pulse shorter than 2 cycles.
- Enable toggle: drop en[0] during clk_out high -> clk_out=0 on the next edge. Re-assert after 3 cycles -> clk_out=1 and tick=1 one edge later, with a full new period.
- Mid-run reset: assert rst_n=0 for 1 cycle while all channels run with loaded div=6 -> all outputs 0. After release, the ratio reverts to 2 (pattern 10) until a new load.
- With CLKGEN_PHASE_EN: ch1 div=4 phase=2, enabled -> pattern 0011 starting on the first edge, with the first tick on the third edge. phase=7 -> treated as 0, so the pattern is 1100.
